// File: rtl/pocket_lab_pkg.sv
// Shared encodings for the pocket-lab capture path.
package pocket_lab_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_FLUSH   = 2'd3
  } cap_state_e;

  localparam logic [1:0] CAP_MODE_IMM  = 2'd0;
  localparam logic [1:0] CAP_MODE_EXT  = 2'd1;
  localparam logic [1:0] CAP_MODE_RISE = 2'd2;
  localparam logic [1:0] CAP_MODE_FALL = 2'd3;

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchronizer for an asynchronous trigger plus a registered rising-edge pulse.
module trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  output logic edge_pulse
);

  logic sync1_q, sync2_q, sync3_q, pulse_q;

  // Synchronize, then register the 0->1 transition as a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= trig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pulse_q <= sync2_q & ~sync3_q;
    end
  end

  assign edge_pulse = pulse_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Trigger-qualified capture sequencer: discards ADC samples until a trigger, then forwards
// exactly the configured number of samples with a regenerated tlast.
module adc_capture_ctrl
  import pocket_lab_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cfg_arm,
  input  logic              cfg_abort,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_trig_sel,
  input  logic [DATA_W-1:0] cfg_level,
  input  logic [LEN_W-1:0]  cfg_length,
  input  logic [1:0]        triggers,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [1:0]        state_o,
  output logic              done,
  output logic [LEN_W-1:0]  beat_count
);

  cap_state_e        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;

  logic              sel_mux, edge_pulse, trig;
  logic              s_hs, m_hs;
  logic [LEN_W-1:0]  cnt_inc;
  logic              unused_tlast;

  assign unused_tlast = s_axis_tlast;

  // Follow the live selection while idle so the synchronizer is already settled at arm time.
  assign sel_mux = (state_q == CAP_IDLE) ? cfg_trig_sel : sel_q;

  trig_sync u_trig_sync (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .trig_in    (triggers[sel_mux]),
    .edge_pulse (edge_pulse)
  );

  // Input ready: free-running while idle/armed so the ADC never stalls there.
  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state_q)
      CAP_IDLE, CAP_ARMED: s_axis_tready = 1'b1;
      CAP_CAPTURE:         s_axis_tready = (!m_valid_q || m_axis_tready) && !cfg_abort;
      CAP_FLUSH:           s_axis_tready = 1'b0;
    endcase
  end

  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign m_hs    = m_valid_q && m_axis_tready;
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, output register and trigger qualification.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    level_d     = level_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    done_d      = 1'b0;
    pend_d      = pend_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    trig        = 1'b0;

    if (m_hs) begin
      m_valid_d = 1'b0;
      beat_d    = beat_q + 1'b1;
    end

    unique case (state_q)
      CAP_IDLE: begin
        if (cfg_arm) begin
          mode_d      = cfg_mode;
          sel_d       = cfg_trig_sel;
          level_d     = cfg_level;
          len_d       = (cfg_length == '0) ? LEN_W'(1) : cfg_length;
          beat_d      = '0;
          pend_d      = 1'b0;
          have_prev_d = 1'b0;
          state_d     = CAP_ARMED;
        end
      end
      CAP_ARMED: begin
        if (mode_q == CAP_MODE_EXT && edge_pulse) pend_d = 1'b1;
        if (s_hs) begin
          unique case (mode_q)
            CAP_MODE_IMM:  trig = 1'b1;
            CAP_MODE_EXT:  trig = edge_pulse || pend_q;
            CAP_MODE_RISE: trig = have_prev_q && (prev_q < level_q) && (s_axis_tdata >= level_q);
            CAP_MODE_FALL: trig = have_prev_q && (prev_q >= level_q) && (s_axis_tdata < level_q);
          endcase
          prev_d      = s_axis_tdata;
          have_prev_d = 1'b1;
          if (trig) begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata;
            m_last_d  = (len_q == LEN_W'(1));
            cnt_d     = LEN_W'(1);
            state_d   = (len_q == LEN_W'(1)) ? CAP_FLUSH : CAP_CAPTURE;
          end
        end
      end
      CAP_CAPTURE: begin
        if (s_hs) begin
          m_valid_d = 1'b1;
          m_data_d  = s_axis_tdata;
          cnt_d     = cnt_inc;
          m_last_d  = (cnt_inc == len_q);
          if (cnt_inc == len_q) state_d = CAP_FLUSH;
        end
      end
      CAP_FLUSH: begin
        if (m_hs && m_last_q) begin
          done_d  = 1'b1;
          state_d = CAP_IDLE;
        end
      end
    endcase

    // Abort overrides everything, including a same-cycle arm.
    if (cfg_abort) begin
      if (m_valid_q && !m_axis_tready) begin
        m_valid_d = 1'b1;
        m_data_d  = m_data_q;
        m_last_d  = 1'b1;
        state_d   = CAP_FLUSH;
      end else begin
        // A beat completing this very cycle becomes the final one.
        m_valid_d = 1'b0;
        done_d    = m_hs;
        state_d   = CAP_IDLE;
        beat_d    = m_hs ? beat_q + 1'b1 : beat_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= CAP_IDLE;
      mode_q      <= CAP_MODE_IMM;
      sel_q       <= 1'b0;
      level_q     <= '0;
      len_q       <= LEN_W'(1);
      cnt_q       <= '0;
      beat_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      level_q     <= level_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign state_o       = state_q;
  assign done          = done_q;
  assign beat_count    = beat_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus pushes expected beats, a monitor pops them.
module tb_adc_capture_ctrl;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        cfg_arm, cfg_abort, cfg_trig_sel;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_level;
  logic [15:0] cfg_length;
  logic        trig0, trig1;
  logic [1:0]  triggers;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  state_o;
  logic        done;
  logic [15:0] beat_count;

  assign triggers = {trig1, trig0};

  adc_capture_ctrl #(.DATA_W(8), .LEN_W(16)) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_mode      (cfg_mode),
    .cfg_trig_sel  (cfg_trig_sel),
    .cfg_level     (cfg_level),
    .cfg_length    (cfg_length),
    .triggers      (triggers),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .state_o       (state_o),
    .done          (done),
    .beat_count    (beat_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] seq[$];
  int         idx = 0;
  bit         stream_en = 0;
  int         ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 stalled
  bit         tog_en = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge axi_aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC source: presents seq[] in order, advancing only on an observed handshake.
  initial begin
    bit hs;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge axi_aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge axi_aclk);
      #1;
      if (hs) idx++;
      s_axis_tvalid = stream_en && (idx < seq.size());
      s_axis_tdata  = s_axis_tvalid ? seq[idx] : 8'h00;
      s_axis_tlast  = 1'($urandom_range(0, 1));
    end
  end

  // Downstream ready pattern.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axi_aclk);
      #1;
      case (ready_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = ~m_axis_tready;
        2: m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Noise on the unselected trigger.
  initial begin
    trig0 = 1'b0;
    forever begin
      @(posedge axi_aclk);
      #3;
      if (tog_en) trig0 = ~trig0;
    end
  end

  // Monitor: scoreboard pops, stall stability, input back-pressure, done timing.
  initial begin
    bit         exp_done = 0;
    bit         held = 0;
    logic [7:0] held_data = '0;
    beat_t      e;
    forever begin
      @(negedge axi_aclk);
      if (!axi_aresetn) begin
        exp_done = 0;
        held = 0;
      end else begin
        if (done) done_cnt++;
        if (done || exp_done) begin
          checks++;
          if (done !== exp_done) begin
            failures++;
            $display("FAIL done_pulse: got %0b expected %0b", done, exp_done);
          end
        end
        exp_done = 0;
        if (held) begin
          checks++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data) begin
            failures++;
            $display("FAIL stall_hold: got v=%0b d=%0h expected v=1 d=%0h",
                     m_axis_tvalid, m_axis_tdata, held_data);
          end
        end
        held      = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
        if (held) begin
          checks++;
          if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL s_ready_backpressure: got %0b expected 0", s_axis_tready);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got d=%0h l=%0b expected none", m_axis_tdata,
                     m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
              failures++;
              $display("FAIL beat: got d=%0h l=%0b expected d=%0h l=%0b", m_axis_tdata,
                       m_axis_tlast, e.data, e.last);
            end
            if (m_axis_tlast) exp_done = 1;
          end
        end
      end
    end
  end

  // Reference: index of the trigger sample in the accepted stream, or -1.
  function automatic int find_trig(input logic [1:0] mode, input logic [7:0] lvl);
    if (mode == 2'd0) return (seq.size() > 0) ? 0 : -1;
    for (int i = 1; i < seq.size(); i++) begin
      if (mode == 2'd2 && seq[i-1] < lvl && seq[i] >= lvl) return i;
      if (mode == 2'd3 && seq[i-1] >= lvl && seq[i] < lvl) return i;
    end
    return -1;
  endfunction

  task automatic push_exp(input int t, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq[t+i];
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic rand_seq(input int n);
    seq.delete();
    for (int i = 0; i < n; i++) seq.push_back(8'($urandom_range(0, 255)));
  endtask

  // Arm with the given config; a returns the cycle number at which arm was driven.
  task automatic arm(input logic [1:0] mode, input logic sel, input logic [7:0] lvl,
                     input logic [15:0] len, output int a);
    repeat (3) @(posedge axi_aclk);
    #2;
    idx          = 0;
    stream_en    = 1;
    cfg_mode     = mode;
    cfg_trig_sel = sel;
    cfg_level    = lvl;
    cfg_length   = len;
    cfg_arm      = 1'b1;
    a            = cyc;
    @(posedge axi_aclk);
    #2;
    cfg_arm    = 1'b0;
    // Later config changes must not matter.
    cfg_mode   = 2'($urandom_range(0, 3));
    cfg_level  = 8'($urandom_range(0, 255));
    cfg_length = 16'($urandom_range(0, 9));
  endtask

  task automatic abort_pulse();
    @(posedge axi_aclk);
    #2;
    cfg_abort = 1'b1;
    @(posedge axi_aclk);
    #2;
    cfg_abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < max_cyc) begin
      @(posedge axi_aclk);
      n++;
    end
    #2;
    if (done_cnt == start) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, max_cyc);
    end
    stream_en = 0;
  endtask

  task automatic end_checks(input string name, input int beats);
    chk({name, "_state"}, 32'(state_o), 32'd0);
    chk({name, "_beat_count"}, 32'(beat_count), 32'(beats));
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int a, b, t, len;
    logic [1:0] mode;
    logic [7:0] lvl;
    axi_aresetn  = 1'b0;
    cfg_arm      = 1'b0;
    cfg_abort    = 1'b0;
    cfg_mode     = 2'd0;
    cfg_trig_sel = 1'b0;
    cfg_level    = '0;
    cfg_length   = '0;
    trig1        = 1'b0;
    #12;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_beat_count", 32'(beat_count), 32'd0);
    chk("reset_s_tready", 32'(s_axis_tready), 32'd1);
    axi_aresetn = 1'b1;

    // Immediate mode, ramp.
    seq.delete();
    for (int i = 0; i < 24; i++) seq.push_back(8'(10 + i));
    push_exp(0, 4);
    arm(2'd0, 1'b0, 8'h00, 16'd4, a);
    wait_done("imm_ramp", 100);
    end_checks("imm_ramp", 4);

    // Rising level crossing; leading 0x90 only seeds prev.
    seq.delete();
    seq.push_back(8'h90); seq.push_back(8'h70); seq.push_back(8'h7F);
    seq.push_back(8'h80); seq.push_back(8'h90);
    for (int i = 0; i < 6; i++) seq.push_back(8'($urandom_range(0, 255)));
    chk("model_rise_index", 32'(find_trig(2'd2, 8'h80)), 32'd3);
    push_exp(3, 2);
    arm(2'd2, 1'b0, 8'h80, 16'd2, a);
    wait_done("rise_level", 100);
    end_checks("rise_level", 2);

    // External trigger on triggers[1] while triggers[0] toggles.
    rand_seq(60);
    arm(2'd1, 1'b1, 8'h00, 16'd3, a);
    tog_en = 1;
    repeat (4) @(posedge axi_aclk);
    #2;
    trig1 = 1'b1;
    b = cyc;
    // Edge seen at cycle b+1 becomes eligible 3 cycles later; seq[0] was accepted at a+2.
    t = b + 4 - (a + 2);
    push_exp(t, 3);
    repeat (5) @(posedge axi_aclk);
    #2;
    trig1 = 1'b0;
    wait_done("ext_trig", 100);
    tog_en = 0;
    trig0  = 1'b0;
    end_checks("ext_trig", 3);

    // Toggling backpressure.
    rand_seq(30);
    push_exp(0, 8);
    ready_mode = 1;
    arm(2'd0, 1'b0, 8'h00, 16'd8, a);
    wait_done("backpressure", 200);
    ready_mode = 0;
    end_checks("backpressure", 8);

    // Abort in CAPTURE with a stalled beat.
    rand_seq(20);
    exp_q.push_back('{data: seq[0], last: 1'b1});
    ready_mode = 3;
    arm(2'd0, 1'b0, 8'h00, 16'd8, a);
    repeat (4) @(posedge axi_aclk);
    abort_pulse();
    chk("abort_cap_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("abort_cap_tlast", 32'(m_axis_tlast), 32'd1);
    chk("abort_cap_tdata", 32'(m_axis_tdata), 32'(seq[0]));
    chk("abort_cap_state", 32'(state_o), 32'd3);
    ready_mode = 0;
    wait_done("abort_capture", 50);
    end_checks("abort_capture", 1);

    // Abort while ARMED with no trigger.
    seq.delete();
    for (int i = 0; i < 20; i++) seq.push_back(8'($urandom_range(0, 8'h3F)));
    arm(2'd2, 1'b0, 8'h80, 16'd4, a);
    repeat (5) @(posedge axi_aclk);
    abort_pulse();
    stream_en = 0;
    chk("abort_armed_state", 32'(state_o), 32'd0);
    chk("abort_armed_tvalid", 32'(m_axis_tvalid), 32'd0);
    end_checks("abort_armed", 0);

    // Reset mid-capture.
    rand_seq(40);
    push_exp(0, 20);
    arm(2'd0, 1'b0, 8'h00, 16'd20, a);
    repeat (5) @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b0;
    #1;
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mid_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_mid_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_beat_count", 32'(beat_count), 32'd0);
    exp_q.delete();
    stream_en = 0;
    @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b1;

    // Length 0 behaves as 1.
    rand_seq(10);
    push_exp(0, 1);
    arm(2'd0, 1'b0, 8'h00, 16'd0, a);
    wait_done("len_zero", 50);
    end_checks("len_zero", 1);

    // Randomized captures against the reference.
    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 2))
        0: mode = 2'd0;
        1: mode = 2'd2;
        default: mode = 2'd3;
      endcase
      lvl = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 6);
      rand_seq(30);
      t = find_trig(mode, lvl);
      ready_mode = 2;
      if (t >= 0) begin
        while (seq.size() < t + ((len == 0) ? 1 : len)) seq.push_back(8'($urandom_range(0, 255)));
        push_exp(t, (len == 0) ? 1 : len);
        arm(mode, 1'b0, lvl, 16'(len), a);
        wait_done("rand_capture", 300);
        end_checks("rand_capture", (len == 0) ? 1 : len);
      end else begin
        arm(mode, 1'b0, lvl, 16'(len), a);
        for (int n = 0; n < 100 && idx < seq.size(); n++) @(posedge axi_aclk);
        abort_pulse();
        stream_en = 0;
        end_checks("rand_no_trigger", 0);
      end
      ready_mode = 0;
    end

    repeat (5) @(posedge axi_aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Trigger-qualified capture sequencer between the ADC AXI4-Stream source and the ccu. When armed, it discards free-running ADC samples until a trigger condition occurs. It then forwards exactly cfg_length samples downstream with a regenerated tlast on the final beat. Trigger sources are immediate, an external test-trigger edge, or an ADC level crossing.

Parameters:
DATA_W, 8, ADC sample width
LEN_W, 16, width of capture length and beat counter

Ports:
axi_aclk  in  1  system clock
axi_aresetn  in  1  asynchronous active-low reset
cfg_arm  in  1  one-cycle pulse; latches cfg_* and starts a capture
cfg_abort  in  1  one-cycle pulse; terminates capture
cfg_mode  in  2  0 immediate, 1 ext-trigger rising edge, 2 level rising crossing, 3 level falling crossing
cfg_trig_sel  in  1  selects triggers[0] or triggers[1]
cfg_level  in  DATA_W  unsigned level threshold
cfg_length  in  LEN_W  number of samples to capture; 0 treated as 1
triggers  in  2  asynchronous external triggers
s_axis_tvalid  in  1  ADC stream valid
s_axis_tready  out  1  ADC stream ready
s_axis_tdata  in  DATA_W  ADC sample
s_axis_tlast  in  1  ignored
m_axis_tvalid  out  1  capture stream valid
m_axis_tready  in  1  capture stream ready
m_axis_tdata  out  DATA_W  captured sample
m_axis_tlast  out  1  last captured sample
state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 FLUSH
done  out  1  one-cycle pulse on the final beat handshake
beat_count  out  LEN_W  beats delivered in the current or last capture

Behaviour:
- Clock and reset: single clock axi_aclk. Asynchronous active-low reset axi_aresetn.
- Reset values: state IDLE; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; done=0; beat_count=0. s_axis_tready is combinational and evaluates to 1 in IDLE.
- Output stage: a single registered beat (m_tvalid/m_tdata/m_tlast). Once m_tvalid=1, data and last hold stable until m_axis_tready.
- IDLE:
  - s_axis_tready=1 and samples are discarded, so the ADC never stalls.
  - On cfg_arm, latch mode, sel, level and length (0→1), clear beat_count, and go to ARMED.
- ARMED:
  - s_axis_tready=1.
  - mode 0: the first accepted sample is the trigger sample.
  - mode 1: the selected trigger passes through a 2-flop synchronizer and registered rising-edge detect. The trigger sample is the first sample accepted on or after the cycle the edge pulse is seen. The edge is remembered until then.
  - mode 2: trigger when prev < level and cur ≥ level.
  - mode 3: trigger when prev ≥ level and cur < level.
  - prev is the last accepted sample. The first sample after arming only seeds prev and cannot trigger.
  - On trigger, the trigger sample is loaded into the output register as beat 1, tlast=(length==1), and state goes to CAPTURE (or FLUSH when length==1).
- CAPTURE:
  - s_axis_tready = !m_tvalid | m_tready.
  - Each accepted sample loads the output register.
  - The sample-load counter sets tlast on load number length, then state goes to FLUSH.
  - ADC samples arriving while s_tready=0 are back-pressured. The ADC source owns overflow.
- FLUSH:
  - s_axis_tready=0.
  - On m handshake with tlast: done=1 for one cycle, state IDLE.
- beat_count increments on every m handshake.
- Abort (any state):
  - No pending beat: go straight to IDLE.
  - Pending beat: force its tlast=1, go to FLUSH, stop accepting input. done pulses when that beat completes.
  - Abort wins over a simultaneous arm.
- cfg_arm outside IDLE is ignored. cfg_* changes after arm have no effect.
- Trigger and final accept in the same cycle: handled by the per-state rules above, no extra latency.
- Latency: accepted sample → m_tvalid is 1 cycle. External edge → eligible trigger is 3 cycles.

Decomposition:
- Shared package pocket_lab_pkg:
  - capture mode encodings CAP_MODE_IMM, CAP_MODE_EXT, CAP_MODE_RISE, CAP_MODE_FALL
  - state encodings CAP_IDLE, CAP_ARMED, CAP_CAPTURE, CAP_FLUSH
- Sub-module trig_sync: 2-flop synchronizer plus registered rising-edge pulse, instantiated once on the selected trigger.

Test Plan:
- Mode 0, length 4, continuous ramp 10,11,12…, m_tready=1 → m beats 10..13, tlast on 13, done one cycle after the 13 handshake, beat_count=4, state IDLE.
- Mode 2, level 0x80, samples 0x70,0x7F,0x80,0x90, length 2 → outputs 0x80,0x90, tlast on 0x90. A 0x90 sample directly after arming, with no prior sample, must not trigger.
- Mode 1, sel 1, triggers[1] pulse 5 cycles wide mid-stream, length 3 → first output is the first sample accepted ≥3 cycles after the edge. triggers[0] toggling has no effect.
- Backpressure: length 8, m_tready toggling 1/0 → no lost or duplicated beats, data stable while stalled, s_axis_tready low whenever the output beat is held.
- Abort during CAPTURE with a pending beat and m_tready=0 → beat held, tlast=1, done when released. Abort in ARMED → IDLE with no m_tvalid.
- Reset asserted mid-CAPTURE → all outputs at reset values immediately. Re-arm with length 0 → exactly one beat, with tlast=1.
